// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Data-memory port between the single-cycle CPU core and a slower, handshaked
// data memory. CPU stores are absorbed into a DEPTH-entry FIFO so that `sw`
// retires in one cycle. The FIFO drains to memory in the background. A load is
// served either by forwarding from the FIFO or by a stalled memory read that
// bypasses the buffered stores.
//
// Build option:
//   STORE_BUFFER_FORWARD_EN
//     defined   : loads that match a buffered store are forwarded with no stall.
//     undefined : no forwarding comparators. A load stalls until the FIFO has
//                 drained, then reads memory.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-low reset
//   cpu_addr   load/store byte address (word granular, bits [1:0] ignored)
//   cpu_wdata  store data
//   cpu_write  store request (wins over cpu_read when both are high)
//   cpu_read   load request
//   cpu_rdata  load data, 0 when no load is being returned
//   stall      core must hold PC and the current instruction
//   mem_req    memory request valid
//   mem_we     1 = write, 0 = read
//   mem_addr   memory word address (low 2 bits forced to 0)
//   mem_wdata  memory write data
//   mem_ack    memory accepts/completes the request this cycle
//   mem_rdata  read data, valid with mem_ack on a read
//   count      current FIFO occupancy
//   drained    FIFO empty and FSM idle
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [DW-1:0]          cpu_wdata,
    input  logic                   cpu_write,
    input  logic                   cpu_read,
    output logic [DW-1:0]          cpu_rdata,
    output logic                   stall,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    input  logic                   mem_ack,
    input  logic [DW-1:0]          mem_rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drained
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = AW - 2;

`ifdef STORE_BUFFER_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WRITE, READ, RDONE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] rdata_q;
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;

    logic          load_req, full, push, pop;
    logic          hit, rd_pending, read_from_idle, read_after_pop;
    logic [DW-1:0] fwd_data;
    logic          unused_addr_lsb;

    // Stores only ever see word addresses; the byte offset is dropped.
    assign unused_addr_lsb = ^cpu_addr[1:0];

    // A simultaneous read and write is a store.
    assign load_req = cpu_read & ~cpu_write;
    // Full is judged on the registered count, so a same-cycle pop never
    // lets a store in early.
    assign full     = (count_q == CW'(DEPTH));
    assign push     = cpu_write & ~full;
    assign pop      = (state_q == WRITE) & mem_ack;

`ifdef STORE_BUFFER_FORWARD_EN
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((i < int'(count_q)) && (addr_q[idx] == cpu_addr[AW-1:2])) begin
                hit      = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign fwd_data = '0;
`endif

    assign rd_pending = load_req & ~hit;
    // Without forwarding, a read may only start once every older store is in
    // memory; with forwarding, a miss can never alias a buffered store.
    assign read_from_idle = rd_pending & (FWD | (count_q == '0));
    assign read_after_pop = rd_pending & (FWD | (count_q == CW'(1)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage and read capture carry no reset; control qualifies them.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[tail_q] <= cpu_addr[AW-1:2];
            data_q[tail_q] <= cpu_wdata;
        end
        if ((state_q == READ) && mem_ack) rdata_q <= mem_rdata;
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall     = 1'b0;
        cpu_rdata = '0;

        case (state_q)
            IDLE: begin
                if (read_from_idle)      state_d = READ;
                else if (count_q != '0)  state_d = WRITE;
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr_q[head_q], 2'b00};
                mem_wdata = data_q[head_q];
                if (mem_ack) begin
                    if (read_after_pop)         state_d = READ;
                    else if (count_q > CW'(1))  state_d = WRITE;
                    else                        state_d = IDLE;
                end
            end
            READ: begin
                mem_req  = 1'b1;
                mem_addr = {cpu_addr[AW-1:2], 2'b00};
                if (mem_ack) state_d = RDONE;
            end
            RDONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (cpu_write) begin
            stall = full;
        end else if (load_req) begin
            if (state_q == RDONE)  cpu_rdata = rdata_q;
            else if (hit)          cpu_rdata = fwd_data;
            else                   stall = 1'b1;
        end
    end

    assign count   = count_q;
    assign drained = (count_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Bench for store_buffer (DEPTH=4, AW=DW=32). Memory writes and load results
// are predicted into queues when stimulus is driven and compared when the DUT
// produces them. Expectations follow the STORE_BUFFER_FORWARD_EN setting.
// -----------------------------------------------------------------------------
module tb_store_buffer;
    logic        clock;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_write;
    logic        cpu_read;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [2:0]  count;
    logic        drained;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_wr [$];   // {addr, data} of expected memory writes
    logic [31:0] exp_rd [$];   // expected load results
    logic [31:0] exp_rd_addr;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_write (cpu_write),
        .cpu_read  (cpu_read),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .count     (count),
        .drained   (drained)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshakes complete at the next rising edge; inspect them mid-cycle.
    always @(negedge clock) begin
        if (reset && mem_req && mem_ack) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", {mem_addr, mem_wdata}, 64'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_wr.pop_front();
                    check("wr_addr", mem_addr, e[63:32]);
                    check("wr_data", mem_wdata, e[31:0]);
                end
            end else begin
                check("rd_addr", mem_addr, exp_rd_addr);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        cpu_write = 1'b1;
        cpu_read  = 1'b0;
        cpu_addr  = addr;
        cpu_wdata = data;
        exp_wr.push_back({addr & 32'hFFFF_FFFC, data});
        #1;
        check("store_stall", stall, 1'b0);
        cyc();
        cpu_write = 1'b0;
    endtask

    // Hold a load until the DUT releases stall. Writes are acked at once, the
    // read is acked after `lat` extra READ cycles.
    task automatic do_load(input logic [31:0] addr, input logic [31:0] exp_val,
                           input logic [31:0] mdata, input int lat,
                           input int exp_cnt, input logic exp_stall0);
        int  rd_wait;
        bit  done;
        rd_wait     = 0;
        done        = 0;
        cpu_write   = 1'b0;
        cpu_read    = 1'b1;
        cpu_addr    = addr;
        mem_rdata   = mdata;
        exp_rd_addr = addr & 32'hFFFF_FFFC;
        exp_rd.push_back(exp_val);
        for (int n = 0; n < 100 && !done; n++) begin
            #1;
            if (n == 0) check("load_stall0", stall, exp_stall0);
            if (!stall) begin
                check("load_data", cpu_rdata, exp_rd.pop_front());
                mem_ack = 1'b0;
                done    = 1;
            end else begin
                if (mem_req && mem_we) begin
                    mem_ack = 1'b1;
                end else if (mem_req) begin
                    mem_ack = (rd_wait == lat);
                    if (rd_wait == lat) check("count_at_read", count, exp_cnt);
                    rd_wait++;
                end else begin
                    mem_ack = 1'b0;
                end
                cyc();
            end
        end
        check("load_timeout", done, 1'b1);
        if (!done) exp_rd.delete();
        cyc();
        cpu_read = 1'b0;
        mem_ack  = 1'b0;
    endtask

    task automatic drain();
        mem_ack = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (drained) break;
            cyc();
        end
        check("drain_done", drained, 1'b1);
        check("drain_queue_empty", exp_wr.size(), 0);
        mem_ack = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_write = 1'b0;
        cpu_read  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        exp_rd_addr = '0;
        cyc();
        cyc();
        check("rst_stall", stall, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_drained", drained, 1'b1);
        check("rst_rdata", cpu_rdata, 32'd0);
        reset = 1'b1;
        cyc();

        // Single store held on the memory port until acked.
        do_store(32'h10, 32'hA5A5_0001);
        check("t1_count", count, 3'd1);
        cyc();
        for (int i = 0; i < 5; i++) begin
            check("t1_req", mem_req, 1'b1);
            check("t1_we", mem_we, 1'b1);
            check("t1_addr", mem_addr, 32'h10);
            check("t1_wdata", mem_wdata, 32'hA5A5_0001);
            cyc();
        end
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        check("t1_count_after", count, 3'd0);
        check("t1_drained", drained, 1'b1);

        // Fill the FIFO, then a fifth store stalls until a slot frees.
        for (int i = 0; i < 4; i++) do_store(32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i));
        check("t2_count_full", count, 3'd4);
        cpu_write = 1'b1;
        cpu_addr  = 32'h110;
        cpu_wdata = 32'hB000_0004;
        #1;
        check("t2_full_stall", stall, 1'b1);
        cyc();
        check("t2_count_held", count, 3'd4);
        mem_ack = 1'b1;
        #1;
        check("t2_stall_with_pop", stall, 1'b1);
        cyc();
        mem_ack = 1'b0;
        check("t2_count_after_pop", count, 3'd3);
        check("t2_stall_released", stall, 1'b0);
        exp_wr.push_back({32'h110, 32'hB000_0004});
        cyc();
        cpu_write = 1'b0;
        check("t2_count_refill", count, 3'd4);
        drain();

        // Two stores to one word, then a load of that word.
        do_store(32'h20, 32'h11);
        do_store(32'h20, 32'h22);
`ifdef STORE_BUFFER_FORWARD_EN
        do_load(32'h23, 32'h22, 32'h0, 0, 0, 1'b0);
`else
        do_load(32'h23, 32'h22, 32'h22, 0, 0, 1'b1);
`endif
        drain();

        // Load miss while one store is buffered but not yet draining.
        do_store(32'h80, 32'h8080_0001);
`ifdef STORE_BUFFER_FORWARD_EN
        do_load(32'h40, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2, 1, 1'b1);
`else
        do_load(32'h40, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2, 0, 1'b1);
`endif
        check("t4_rdata_idle", cpu_rdata, 32'd0);
        drain();

        // Read and write together act as a store only.
        cpu_write = 1'b1;
        cpu_read  = 1'b1;
        cpu_addr  = 32'h30;
        cpu_wdata = 32'h3030_3030;
        exp_wr.push_back({32'h30, 32'h3030_3030});
        #1;
        check("t5_stall", stall, 1'b0);
        check("t5_no_req", mem_req, 1'b0);
        cyc();
        cpu_write = 1'b0;
        cpu_read  = 1'b0;
        check("t5_count", count, 3'd1);
        cyc();
        check("t5_req", mem_req, 1'b1);
        check("t5_we", mem_we, 1'b1);
        drain();

        // Reset in the middle of a write with three stores buffered.
        for (int i = 0; i < 3; i++) do_store(32'h200 + 32'(4 * i), 32'hC000_0000 + 32'(i));
        check("t6_req_before", mem_req, 1'b1);
        check("t6_count_before", count, 3'd3);
        #2;
        reset = 1'b0;
        #1;
        check("t6_req_async", mem_req, 1'b0);
        check("t6_count_async", count, 3'd0);
        check("t6_drained_async", drained, 1'b1);
        exp_wr.delete();
        mem_ack = 1'b1;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        check("t6_count_after", count, 3'd0);
        check("t6_req_after", mem_req, 1'b0);
        check("t6_drained_after", drained, 1'b1);
        mem_ack = 1'b0;

        check("end_wr_queue", exp_wr.size(), 0);
        check("end_rd_queue", exp_rd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
